// File: rtl/lcd_nibble_receiver.sv
// lcd_nibble_receiver: display-side checker and byte reassembler for the 4-bit HD44780 LCD bus
module lcd_nibble_receiver #(
  parameter int MIN_EN_HIGH = 12,
  parameter int WAIT_PWR = 750000,
  parameter int WAIT_4MS = 205000,
  parameter int WAIT_100US = 5000,
  parameter int WAIT_40US = 2000,
  parameter int NIB_GAP = 50,
  parameter int CNT_W = 20
) (
  input logic CLK,
  input logic RST,
  input logic LCD_E,
  input logic [3:0] LCD_D,
  input logic LCD_RS,
  input logic LCD_RW,
  input logic ERR_CLR,
  output logic [7:0] BYTE_OUT,
  output logic RS_OUT,
  output logic BYTE_VLD,
  output logic INI_DETECT,
  output logic ERR_TIMING,
  output logic ERR_SEQ
);
  localparam int HW = $clog2(MIN_EN_HIGH + 1);
  typedef enum logic [2:0] {S_PWR, S_I1, S_I2, S_I3, S_HI, S_LO} state_t;
  state_t r_state;
  logic r_e_d, r_rs_q, r_rw_q, r_hi_rs;
  logic [HW-1:0] r_hi_cnt;
  logic [3:0] r_nib_q, r_hi_nib;
  logic [CNT_W-1:0] r_gap, w_need;
  logic w_fall, w_short, w_acc, w_init, w_gap_err, w_seq_err;
  always_comb begin
    w_fall = r_e_d && !LCD_E;
    w_short = w_fall && !r_rw_q && r_hi_cnt < HW'(MIN_EN_HIGH);
    w_acc = w_fall && !r_rw_q && !w_short;
    w_init = r_state != S_HI && r_state != S_LO;
    w_need = r_state == S_PWR ? CNT_W'(WAIT_PWR) : r_state == S_I1 ? CNT_W'(WAIT_4MS) :
             r_state == S_I2 ? CNT_W'(WAIT_100US) : r_state == S_LO ? CNT_W'(NIB_GAP) : CNT_W'(WAIT_40US);
    w_gap_err = w_acc && r_gap < w_need;
    w_seq_err = w_acc && (w_init ? r_nib_q != (r_state == S_I3 ? 4'h2 : 4'h3) :
                                   r_state == S_LO && r_rs_q != r_hi_rs);
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      r_state <= S_PWR;
      r_e_d <= 1'b0;
      r_rs_q <= 1'b0;
      r_rw_q <= 1'b0;
      r_hi_rs <= 1'b0;
      r_hi_cnt <= '0;
      r_nib_q <= '0;
      r_hi_nib <= '0;
      r_gap <= '0;
      BYTE_OUT <= '0;
      RS_OUT <= 1'b0;
      BYTE_VLD <= 1'b0;
      INI_DETECT <= 1'b0;
      ERR_TIMING <= 1'b0;
      ERR_SEQ <= 1'b0;
    end else begin
      r_e_d <= LCD_E;
      r_hi_cnt <= !LCD_E ? '0 : r_hi_cnt == HW'(MIN_EN_HIGH) ? r_hi_cnt : r_hi_cnt + 1'b1;
      if (LCD_E) begin
        r_nib_q <= LCD_D;
        r_rs_q <= LCD_RS;
        r_rw_q <= LCD_RW;
      end
      r_gap <= w_acc ? '0 : &r_gap ? r_gap : r_gap + 1'b1;
      BYTE_VLD <= 1'b0;
      ERR_TIMING <= w_short || w_gap_err ? 1'b1 : ERR_CLR ? 1'b0 : ERR_TIMING;
      ERR_SEQ <= w_seq_err ? 1'b1 : ERR_CLR ? 1'b0 : ERR_SEQ;
      if (w_acc) begin
        if (w_init) begin
          r_state <= w_seq_err ? S_PWR : state_t'(r_state + 3'd1);
          if (!w_seq_err && r_state == S_I3) INI_DETECT <= 1'b1;
        end else if (r_state == S_HI) begin
          r_hi_nib <= r_nib_q;
          r_hi_rs <= r_rs_q;
          r_state <= S_LO;
        end else begin
          BYTE_OUT <= {r_hi_nib, r_nib_q};
          RS_OUT <= r_hi_rs;
          BYTE_VLD <= 1'b1;
          r_state <= S_HI;
        end
      end
    end
endmodule

// File: tb/tb_lcd_nibble_receiver.sv
// tb_lcd_nibble_receiver: randomized bench for lcd_nibble_receiver against a strobe-level reference model
module tb_lcd_nibble_receiver;
  localparam int MIN_EN_HIGH = 4;
  localparam int WAIT_PWR = 300;
  localparam int WAIT_4MS = 120;
  localparam int WAIT_100US = 60;
  localparam int WAIT_40US = 30;
  localparam int NIB_GAP = 10;
  localparam int CNT_W = 9;
  localparam int GAP_MAX = (1 << CNT_W) - 1;
  logic CLK = 0, RST = 1, LCD_E = 0, LCD_RS = 0, LCD_RW = 0, ERR_CLR = 0;
  logic [3:0] LCD_D = 0;
  logic [7:0] BYTE_OUT;
  logic RS_OUT, BYTE_VLD, INI_DETECT, ERR_TIMING, ERR_SEQ;
  lcd_nibble_receiver #(
    .MIN_EN_HIGH(MIN_EN_HIGH), .WAIT_PWR(WAIT_PWR), .WAIT_4MS(WAIT_4MS), .WAIT_100US(WAIT_100US),
    .WAIT_40US(WAIT_40US), .NIB_GAP(NIB_GAP), .CNT_W(CNT_W)
  ) dut (
    .CLK(CLK), .RST(RST), .LCD_E(LCD_E), .LCD_D(LCD_D), .LCD_RS(LCD_RS), .LCD_RW(LCD_RW),
    .ERR_CLR(ERR_CLR), .BYTE_OUT(BYTE_OUT), .RS_OUT(RS_OUT), .BYTE_VLD(BYTE_VLD),
    .INI_DETECT(INI_DETECT), .ERR_TIMING(ERR_TIMING), .ERR_SEQ(ERR_SEQ)
  );
  always #5 CLK = ~CLK;
  int vectors = 0, miscompares = 0;
  int n, last, init_cnt;
  int need[4] = '{WAIT_PWR, WAIT_4MS, WAIT_100US, WAIT_40US};
  bit inited, have_hi;
  logic [3:0] hn;
  logic hr;
  logic [7:0] exp_byte;
  logic exp_rs, exp_vld, exp_ini, exp_et, exp_es;
  task automatic chk(input string nm, input logic [7:0] got, input logic [7:0] want);
    vectors++;
    if (got !== want) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h at t=%0t", nm, got, want, $time);
    end
  endtask
  task automatic compare_all;
    chk("BYTE_OUT", BYTE_OUT, exp_byte);
    chk("RS_OUT", {7'd0, RS_OUT}, {7'd0, exp_rs});
    chk("BYTE_VLD", {7'd0, BYTE_VLD}, {7'd0, exp_vld});
    chk("INI_DETECT", {7'd0, INI_DETECT}, {7'd0, exp_ini});
    chk("ERR_TIMING", {7'd0, ERR_TIMING}, {7'd0, exp_et});
    chk("ERR_SEQ", {7'd0, ERR_SEQ}, {7'd0, exp_es});
  endtask
  task automatic tick;
    @(negedge CLK);
    compare_all();
    @(posedge CLK);
    n++;
    if (ERR_CLR) begin
      exp_et = 0;
      exp_es = 0;
    end
    #1 exp_vld = 0;
  endtask
  task automatic idle(input int k);
    repeat (k) tick();
  endtask
  task automatic model(input logic [3:0] nib, input logic rs, input logic rw, input int w);
    int gap, req;
    if (rw) return;
    if (w < MIN_EN_HIGH) begin
      exp_et = 1;
      return;
    end
    gap = n - last - 1;
    if (gap > GAP_MAX) gap = GAP_MAX;
    last = n;
    req = inited ? (have_hi ? NIB_GAP : WAIT_40US) : need[init_cnt];
    if (gap < req) exp_et = 1;
    if (!inited) begin
      if (nib == (init_cnt == 3 ? 4'h2 : 4'h3)) begin
        init_cnt++;
        if (init_cnt == 4) begin
          inited = 1;
          exp_ini = 1;
        end
      end else begin
        exp_es = 1;
        init_cnt = 0;
      end
    end else if (!have_hi) begin
      hn = nib;
      hr = rs;
      have_hi = 1;
    end else begin
      exp_byte = {hn, nib};
      exp_rs = hr;
      exp_vld = 1;
      if (rs != hr) exp_es = 1;
      have_hi = 0;
    end
  endtask
  task automatic strobe(input logic [3:0] nib, input logic rs, input logic rw, input int w, input logic clr);
    LCD_E = 1;
    LCD_D = nib;
    LCD_RS = rs;
    LCD_RW = rw;
    repeat (w) tick();
    LCD_E = 0;
    LCD_D = 4'($urandom);
    LCD_RS = 1'($urandom);
    LCD_RW = 1'($urandom);
    ERR_CLR = clr;
    tick();
    ERR_CLR = 0;
    model(nib, rs, rw, w);
  endtask
  task automatic clear_pulse;
    ERR_CLR = 1;
    tick();
    ERR_CLR = 0;
  endtask
  task automatic do_reset;
    RST = 1;
    LCD_E = 0;
    ERR_CLR = 0;
    exp_byte = 0;
    exp_rs = 0;
    exp_vld = 0;
    exp_ini = 0;
    exp_et = 0;
    exp_es = 0;
    init_cnt = 0;
    inited = 0;
    have_hi = 0;
    #1;
    chk("rst_BYTE_OUT", BYTE_OUT, 8'h00);
    chk("rst_RS_OUT", {7'd0, RS_OUT}, 8'd0);
    chk("rst_BYTE_VLD", {7'd0, BYTE_VLD}, 8'd0);
    chk("rst_INI_DETECT", {7'd0, INI_DETECT}, 8'd0);
    chk("rst_ERR_TIMING", {7'd0, ERR_TIMING}, 8'd0);
    chk("rst_ERR_SEQ", {7'd0, ERR_SEQ}, 8'd0);
    tick();
    tick();
    RST = 0;
    n = 0;
    last = 0;
  endtask
  task automatic do_init;
    idle(WAIT_PWR + 1);
    strobe(4'h3, 0, 0, 5, 0);
    idle(WAIT_4MS);
    strobe(4'h3, 0, 0, 5, 0);
    idle(WAIT_100US);
    strobe(4'h3, 0, 0, 5, 0);
    idle(WAIT_4MS);
    strobe(4'h2, 0, 0, 5, 0);
  endtask
  initial begin
    int k;
    logic rs;
    repeat (2) @(posedge CLK);
    #1;
    do_reset();
    do_init();
    chk("init_ini", {7'd0, INI_DETECT}, 8'd1);
    chk("init_et", {7'd0, ERR_TIMING}, 8'd0);
    chk("init_es", {7'd0, ERR_SEQ}, 8'd0);
    idle(WAIT_40US);
    strobe(4'h2, 0, 0, 5, 0);
    idle(NIB_GAP);
    strobe(4'h8, 0, 0, 5, 0);
    chk("b28_vld", {7'd0, BYTE_VLD}, 8'd1);
    chk("b28_byte", BYTE_OUT, 8'h28);
    chk("b28_rs", {7'd0, RS_OUT}, 8'd0);
    idle(WAIT_40US);
    strobe(4'h7, 0, 0, 2, 0);
    chk("short_et", {7'd0, ERR_TIMING}, 8'd1);
    clear_pulse();
    chk("clr_et", {7'd0, ERR_TIMING}, 8'd0);
    strobe(4'h4, 1, 0, 5, 0);
    idle(NIB_GAP);
    strobe(4'h1, 1, 0, MIN_EN_HIGH, 0);
    chk("b41_byte", BYTE_OUT, 8'h41);
    chk("b41_rs", {7'd0, RS_OUT}, 8'd1);
    idle(WAIT_40US - 5);
    strobe(4'hA, 0, 0, 5, 0);
    chk("gap_exact_et", {7'd0, ERR_TIMING}, 8'd0);
    idle(NIB_GAP - 6);
    strobe(4'h5, 0, 0, 5, 0);
    chk("gap_short_et", {7'd0, ERR_TIMING}, 8'd1);
    chk("gap_short_byte", BYTE_OUT, 8'hA5);
    do_reset();
    idle(WAIT_PWR + 1);
    strobe(4'h3, 0, 0, 5, 0);
    idle(50);
    strobe(4'h3, 0, 0, 5, 0);
    idle(WAIT_100US);
    strobe(4'h3, 0, 0, 5, 0);
    idle(WAIT_4MS);
    strobe(4'h2, 0, 0, 5, 0);
    chk("early_et", {7'd0, ERR_TIMING}, 8'd1);
    chk("early_ini", {7'd0, INI_DETECT}, 8'd1);
    do_reset();
    idle(WAIT_PWR + 1);
    strobe(4'h2, 0, 0, 5, 0);
    chk("badnib_es", {7'd0, ERR_SEQ}, 8'd1);
    chk("badnib_ini", {7'd0, INI_DETECT}, 8'd0);
    clear_pulse();
    chk("badnib_clr", {7'd0, ERR_SEQ}, 8'd0);
    do_reset();
    do_init();
    idle(WAIT_40US);
    strobe(4'h6, 1, 0, 5, 0);
    do_reset();
    idle(NIB_GAP);
    strobe(4'h9, 1, 0, 5, 0);
    chk("rst_mid_vld", {7'd0, BYTE_VLD}, 8'd0);
    chk("rst_mid_ini", {7'd0, INI_DETECT}, 8'd0);
    for (int r = 0; r < 4; r++) begin
      do_reset();
      for (int s = 0; s < 12 && !inited; s++) begin
        k = need[init_cnt] - 5 + $urandom_range(0, 14) - 8;
        idle(k < 0 ? 0 : k);
        strobe($urandom_range(0, 9) == 0 ? 4'($urandom) : (init_cnt == 3 ? 4'h2 : 4'h3),
               1'($urandom), $urandom_range(0, 9) == 0, $urandom_range(3, 6), 0);
      end
      for (int s = 0; s < 60; s++) begin
        k = ($urandom_range(0, 19) == 0) ? $urandom_range(512, 522) : $urandom_range(0, 40);
        idle(k);
        if ($urandom_range(0, 7) == 0) clear_pulse();
        rs = have_hi ? ($urandom_range(0, 7) == 0 ? ~hr : hr) : 1'($urandom);
        strobe(4'($urandom), rs, $urandom_range(0, 9) == 0, $urandom_range(1, 7), $urandom_range(0, 7) == 0);
      end
    end
    tick();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule

// File: doc/lcd_nibble_receiver.md
Name: lcd_nibble_receiver

Overview:
- Receiving end of the 4-bit HD44780-style LCD bus driven by the team's LCD init and command FSMs: the display-side model of the interface.
- Samples LCD_E/LCD_D/LCD_RS, recognises the 3-3-3-2 power-on sequence, then reassembles nibble pairs into bytes.
- Checks enable pulse width and inter-strobe gaps.
- Used as synthesizable loopback checker in simulation and on-board self-test.

Parameters:
- MIN_EN_HIGH, 12: minimum LCD_E high cycles for a valid strobe.
- WAIT_PWR, 750000: minimum cycles from reset release to first strobe (15 ms @ 50 MHz).
- WAIT_4MS, 205000: minimum gap before second 0x3.
- WAIT_100US, 5000: minimum gap before third 0x3.
- WAIT_40US, 2000: minimum gap before 0x2, and between bytes in run mode.
- NIB_GAP, 50: minimum gap between high and low nibble of one byte.
- CNT_W, 20: gap counter width; must hold WAIT_PWR.

Ports:
- CLK  in  1  clock
- RST  in  1  reset
- LCD_E  in  1  enable strobe, same clock domain
- LCD_D  in  4  data nibble (SF_D[11:8])
- LCD_RS  in  1  register select
- LCD_RW  in  1  1 = read cycle
- ERR_CLR  in  1  clears sticky error flags
- BYTE_OUT  out  8  last assembled byte
- RS_OUT  out  1  RS of last assembled byte
- BYTE_VLD  out  1  one-cycle pulse per assembled byte
- INI_DETECT  out  1  init sequence recognised, 4-bit mode active
- ERR_TIMING  out  1  sticky: short pulse or gap violation
- ERR_SEQ  out  1  sticky: wrong init nibble

Behaviour:
- Reset: RST, asynchronous, active-high; clock CLK.
- All outputs 0 on reset, all counters 0, state S_PWR.
- Gap counter restarts from reset release.
- Strobe detection:
  - e_d = LCD_E registered.
  - hi_cnt counts cycles with LCD_E=1, saturating at MIN_EN_HIGH.
  - nib_q captures LCD_D and rs_q captures LCD_RS every cycle LCD_E=1.
  - Falling edge = LCD_E=0 and e_d=1 at a rising CLK edge.
  - Strobe evaluated at that edge; registered outputs update at that same edge.
- Short pulse: hi_cnt < MIN_EN_HIGH at the falling edge sets ERR_TIMING. The strobe is discarded; no state or gap-counter change.
- Read cycle: strobe with rs/rw sampled LCD_RW=1 is ignored entirely.
- Gap counter:
  - Counts cycles since the last accepted strobe's falling edge, saturating at 2^CNT_W-1.
  - Cleared on each accepted strobe.
  - Gap check compares counter against the state's requirement at the strobe's falling edge. Violation sets ERR_TIMING; the strobe is still processed.
- FSM on accepted strobes, with required nibble and minimum gap:
  - S_PWR, 0x3, WAIT_PWR -> S_I1
  - S_I1, 0x3, WAIT_4MS -> S_I2
  - S_I2, 0x3, WAIT_100US -> S_I3
  - S_I3, 0x2, WAIT_40US -> S_HI; INI_DETECT=1 from this edge
  - S_HI, any nibble, WAIT_40US: latch high nibble and RS -> S_LO
  - S_LO, any nibble, NIB_GAP: BYTE_OUT={hi,nib}, RS_OUT=RS latched in S_HI, BYTE_VLD=1 for one cycle -> S_HI
- Wrong nibble in S_PWR..S_I3: set ERR_SEQ, go to S_PWR. Next strobe then needs WAIT_PWR gap from this one.
- RS mismatch between the two nibbles: sets ERR_SEQ; byte still delivered with high-nibble RS.
- BYTE_OUT/RS_OUT hold until the next byte; BYTE_VLD is 0 otherwise.
- ERR_CLR=1 clears both error flags. If ERR_CLR and a new error occur in the same cycle, the error wins.
- Reset mid-operation (e.g. after high nibble) discards the partial byte and returns to S_PWR with INI_DETECT=0.

Test Plan:
- Drive init FSM timing: 750001 idle cycles, 13-cycle pulses of 0x3/0x3/0x3/0x2 with gaps 205000/5000/205000 -> INI_DETECT=1 at 4th falling edge; ERR_TIMING=ERR_SEQ=0.
- After init, RS=0 nibbles 0x2 then 0x8, gaps 2000/50 -> one BYTE_VLD pulse, BYTE_OUT=0x28, RS_OUT=0.
- After init, 5-cycle LCD_E pulse -> ERR_TIMING=1, no BYTE_VLD, state unchanged; next valid byte 0x41 RS=1 -> BYTE_OUT=0x41, RS_OUT=1.
- Second 0x3 only 1000 cycles after the first -> ERR_TIMING=1; sequence still advances and INI_DETECT=1 after remaining valid strobes.
- First strobe nibble 0x2 after 750001 cycles -> ERR_SEQ=1, INI_DETECT=0; ERR_CLR pulse -> ERR_SEQ=0.
- RST asserted after high nibble of a byte -> all outputs 0 immediately; a subsequent low nibble alone produces no BYTE_VLD.
